// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: read-side scheduler sharing one downstream consumer
// between two async_fifo read ports (FIFO0, FIFO1) in the FIFOs' read clock
// domain. Round-robin grants issue single-cycle fifo_rd strobes. The FIFO's
// registered rd_data is captured one cycle later into a 2-entry in-order
// buffer, which feeds a valid/ready output tagged with the source.
//
// Optional feature: define FIFO_ARB_BURST_EN to let the current owner keep
// the grant for up to BURST_LEN consecutive issues while both sources request.
module fifo_rd_arbiter #(
  parameter int bw_data   = 24,
  parameter int cnt_width = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           arb_en,
  input  logic                 empty0,
  input  logic                 empty1,
  input  logic [bw_data-1:0]   rd_data0,
  input  logic [bw_data-1:0]   rd_data1,
  output logic                 fifo_rd0,
  output logic                 fifo_rd1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bw_data-1:0]   out_data,
  output logic                 out_src,
  output logic [cnt_width-1:0] rd_cnt0,
  output logic [cnt_width-1:0] rd_cnt1
);

  // Buffer entries hold {src, data}; entry0 is always the head.
  logic [bw_data:0]   entry0_reg;
  logic [bw_data:0]   entry1_reg;
  logic [1:0]         buf_cnt_reg;
  logic               inflight_reg;
  logic               inflight_src_reg;
  logic               last_grant_reg;
  logic [cnt_width-1:0] rd_cnt0_reg;
  logic [cnt_width-1:0] rd_cnt1_reg;

  logic               req0;
  logic               req1;
  logic               pop;
  logic [2:0]         occupancy;
  logic               issue_ok;
  logic               pick;
  logic               grant_valid;
  logic               grant_src;
  logic [bw_data:0]   cap_word;

  assign req0 = arb_en[0] & ~empty0;
  assign req1 = arb_en[1] & ~empty1;

  assign out_valid = (buf_cnt_reg != 2'd0);
  assign out_data  = entry0_reg[bw_data-1:0];
  assign out_src   = entry0_reg[bw_data];
  assign rd_cnt0   = rd_cnt0_reg;
  assign rd_cnt1   = rd_cnt1_reg;

  assign pop = out_valid & out_ready;

  // Words already owned by the arbiter: buffered plus the one in flight.
  // A new read may start only if it is guaranteed a buffer slot on capture;
  // counting this cycle's pop keeps 1 word/cycle streaming with out_ready high.
  assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg};
  assign issue_ok  = (occupancy <= ({2'b00, pop} + 3'd1));

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
  logic [BW-1:0] burst_cnt_reg;
`endif

  // Grant selection: a lone requester wins; on contention alternate, or
  // (burst build) stay with the owner until it has had BURST_LEN issues.
  always_comb begin
    pick = ~last_grant_reg;
`ifdef FIFO_ARB_BURST_EN
    if ((burst_cnt_reg != '0) && (burst_cnt_reg < BURST_MAX)) begin
      pick = last_grant_reg;
    end
`endif
    grant_src   = (req0 & req1) ? pick : req1;
    grant_valid = issue_ok & (req0 | req1) & ~reset;
  end

  assign fifo_rd0 = grant_valid & ~grant_src;
  assign fifo_rd1 = grant_valid & grant_src;

  // The FIFO presents the strobed word on rd_data one cycle after the strobe.
  assign cap_word = {inflight_src_reg, inflight_src_reg ? rd_data1 : rd_data0};

  // Track the outstanding read and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg     <= 1'b0;
      inflight_src_reg <= 1'b0;
      last_grant_reg   <= 1'b1;
    end else begin
      inflight_reg <= grant_valid;
      if (grant_valid) begin
        inflight_src_reg <= grant_src;
        last_grant_reg   <= grant_src;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // Count consecutive issues to the current owner; a switch starts a new run.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_reg <= '0;
    end else if (grant_valid) begin
      if ((grant_src == last_grant_reg) && (burst_cnt_reg != '0)) begin
        if (burst_cnt_reg != BURST_MAX) begin
          burst_cnt_reg <= burst_cnt_reg + BW'(1);
        end
      end else begin
        burst_cnt_reg <= BW'(1);
      end
    end
  end
`endif

  // In-order 2-entry buffer: captures go to the tail, pops shift toward head.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry0_reg  <= '0;
      entry1_reg  <= '0;
      buf_cnt_reg <= 2'd0;
    end else begin
      case ({inflight_reg, pop})
        2'b01: begin
          entry0_reg  <= entry1_reg;
          buf_cnt_reg <= buf_cnt_reg - 2'd1;
        end
        2'b10: begin
          if (buf_cnt_reg == 2'd0) begin
            entry0_reg <= cap_word;
          end else begin
            entry1_reg <= cap_word;
          end
          buf_cnt_reg <= buf_cnt_reg + 2'd1;
        end
        2'b11: begin
          if (buf_cnt_reg == 2'd1) begin
            entry0_reg <= cap_word;
          end else begin
            entry0_reg <= entry1_reg;
            entry1_reg <= cap_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Per-source capture counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt0_reg <= '0;
      rd_cnt1_reg <= '0;
    end else if (inflight_reg) begin
      if (inflight_src_reg) begin
        rd_cnt1_reg <= rd_cnt1_reg + 1'b1;
      end else begin
        rd_cnt0_reg <= rd_cnt0_reg + 1'b1;
      end
    end
  end

  // A capture into a full buffer without a simultaneous pop would lose data.
  assert property (@(posedge clk) disable iff (reset)
    (inflight_reg && !pop) |-> (buf_cnt_reg != 2'd2));

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: bench-side FIFO models with registered read
// data, a transaction-level scoreboard checked every cycle, and directed tests
// with literal expected sequences.
module tb_fifo_rd_arbiter;

  localparam int DW = 24;
  localparam int CW = 3;   // small counter so wrap-around is reachable
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    arb_en = 2'b00;
  logic          empty0;
  logic          empty1;
  logic [DW-1:0] rd_data0 = '0;
  logic [DW-1:0] rd_data1 = '0;
  logic          fifo_rd0;
  logic          fifo_rd1;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic [CW-1:0] rd_cnt0;
  logic [CW-1:0] rd_cnt1;

  fifo_rd_arbiter #(.bw_data(DW), .cnt_width(CW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .empty0(empty0), .empty1(empty1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .fifo_rd0(fifo_rd0), .fifo_rd1(fifo_rd1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src),
    .rd_cnt0(rd_cnt0), .rd_cnt1(rd_cnt1)
  );

  always #5 clk = ~clk;

  // Bench FIFO models: memory plus pointers; read data registered on the strobe.
  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  assign empty0 = (rp0 == wp0);
  assign empty1 = (rp1 == wp1);

  always @(posedge clk) begin
    if (fifo_rd0) begin
      rd_data0 <= mem0[rp0 % 64];
      rp0 <= rp0 + 1;
    end
    if (fifo_rd1) begin
      rd_data1 <= mem1[rp1 % 64];
      rp1 <= rp1 + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected output words in issue order with earliest visible cycle.
  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    int            rdy;
  } ent_t;
  ent_t q[$];

  int cyc = 0;
  int m_cnt0 = 0, m_cnt1 = 0;
  bit pend = 0, pend_src = 0;
  bit m_last = 1;
  int m_run = 0;
  int pulses0 = 0, pulses1 = 0;
  logic [DW-1:0] got_data[$];
  logic          got_src[$];

  always @(negedge clk) begin
    bit exp_valid, r0, r1, pop, allowed, gv, gs, pk;
    ent_t e;
    cyc++;
    if (reset) begin
      chk("rd0_in_reset", 32'(fifo_rd0), 32'd0);
      chk("rd1_in_reset", 32'(fifo_rd1), 32'd0);
      q.delete();
      pend = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1; m_run = 0;
    end else begin
      exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_src", 32'(out_src), 32'(q[0].src));
      end
      chk("rd_cnt0", 32'(rd_cnt0), 32'(m_cnt0 % (1 << CW)));
      chk("rd_cnt1", 32'(rd_cnt1), 32'(m_cnt1 % (1 << CW)));
      r0 = arb_en[0] && (rp0 != wp0);
      r1 = arb_en[1] && (rp1 != wp1);
      pop = exp_valid && out_ready;
      allowed = (q.size() - int'(pop)) <= 1;
      gv = allowed && (r0 || r1);
      pk = !m_last;
`ifdef FIFO_ARB_BURST_EN
      if (m_run > 0 && m_run < BL) pk = m_last;
`endif
      gs = (r0 && r1) ? pk : r1;
      chk("fifo_rd0", 32'(fifo_rd0), 32'(gv && !gs));
      chk("fifo_rd1", 32'(fifo_rd1), 32'(gv && gs));
      if (fifo_rd0) pulses0++;
      if (fifo_rd1) pulses1++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_src.push_back(out_src);
        $display("t=%0t deliver src=%0d data=%0h", $time, out_src, out_data);
      end
      if (pop) void'(q.pop_front());
      if (pend) begin
        if (pend_src) m_cnt1++; else m_cnt0++;
      end
      pend = gv; pend_src = gs;
      if (gv) begin
        e.src = gs;
        e.data = gs ? mem1[rp1 % 64] : mem0[rp0 % 64];
        e.rdy = cyc + 2;
        q.push_back(e);
        if (gs == m_last && m_run > 0) m_run++; else m_run = 1;
        m_last = gs;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [DW-1:0] w);
    mem0[wp0 % 64] = w;
    wp0++;
  endtask

  task automatic load1(input logic [DW-1:0] w);
    mem1[wp1 % 64] = w;
    wp1++;
  endtask

  task automatic do_reset();
    arb_en = 2'b00;
    reset = 1'b1;
    tick(2);
    wp0 = rp0;
    wp1 = rp1;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic chk_seq(input string name, input int base, input logic [DW-1:0] w[],
                         input logic s[]);
    chk({name, "_count"}, 32'(got_data.size() - base), 32'(w.size()));
    for (int i = 0; i < w.size(); i++) begin
      if (base + i < got_data.size()) begin
        chk(name, 32'(got_data[base + i]), 32'(w[i]));
        chk({name, "_src"}, 32'(got_src[base + i]), 32'(s[i]));
      end
    end
  endtask

  initial begin
    int base, p0, p1;
    logic [DW-1:0] w[];
    logic s[];
    // Reset held 2 cycles with both FIFOs non-empty.
    load0(24'h0000A0); load1(24'h0000B0);
    arb_en = 2'b11;
    tick(2);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_rd_cnt0", 32'(rd_cnt0), 32'd0);
    chk("reset_rd_cnt1", 32'(rd_cnt1), 32'd0);
    do_reset();

    // FIFO0 only, three words streamed.
    base = got_data.size(); p0 = pulses0;
    load0(24'hA1); load0(24'hA2); load0(24'hA3);
    arb_en = 2'b11;
    tick(8);
    w = '{24'hA1, 24'hA2, 24'hA3}; s = '{0, 0, 0};
    chk_seq("single_src", base, w, s);
    chk("single_pulses", 32'(pulses0 - p0), 32'd3);
    chk("single_rd_cnt0", 32'(rd_cnt0), 32'd3);
    do_reset();

    // Both FIFOs with four words each.
    base = got_data.size();
    for (int i = 1; i <= 4; i++) begin
      load0(24'hA0 + 24'(i));
      load1(24'hB0 + 24'(i));
    end
    arb_en = 2'b11;
    tick(14);
`ifdef FIFO_ARB_BURST_EN
    w = '{24'hA1, 24'hA2, 24'hB1, 24'hB2, 24'hA3, 24'hA4, 24'hB3, 24'hB4};
    s = '{0, 0, 1, 1, 0, 0, 1, 1};
`else
    w = '{24'hA1, 24'hB1, 24'hA2, 24'hB2, 24'hA3, 24'hB3, 24'hA4, 24'hB4};
    s = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    chk_seq("both_src", base, w, s);
    chk("both_rd_cnt0", 32'(rd_cnt0), 32'd4);
    chk("both_rd_cnt1", 32'(rd_cnt1), 32'd4);
    do_reset();

    // Back-pressure: only two reads may be outstanding.
    base = got_data.size(); p0 = pulses0;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) load0(24'hC0 + 24'(i));
    arb_en = 2'b01;
    tick(8);
    chk("bp_pulses", 32'(pulses0 - p0), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'hC1);
    out_ready = 1'b1;
    tick(10);
    w = '{24'hC1, 24'hC2, 24'hC3, 24'hC4, 24'hC5}; s = '{0, 0, 0, 0, 0};
    chk_seq("bp_drain", base, w, s);
    chk("bp_rd_cnt0", 32'(rd_cnt0), 32'd5);

    // FIFO1 disabled; FIFO0 count wraps 7 -> 0.
    base = got_data.size(); p1 = pulses1;
    for (int i = 1; i <= 3; i++) begin
      load0(24'hD0 + 24'(i));
      load1(24'hE0 + 24'(i));
    end
    arb_en = 2'b01;
    tick(10);
    chk("dis_rd1_pulses", 32'(pulses1 - p1), 32'd0);
    w = '{24'hD1, 24'hD2, 24'hD3}; s = '{0, 0, 0};
    chk_seq("dis_deliver", base, w, s);
    chk("wrap_rd_cnt0", 32'(rd_cnt0), 32'd0);

    // Disable FIFO0 right after its grant: granted word still delivered.
    arb_en = 2'b00;
    tick(1);
    base = got_data.size(); p0 = pulses0;
    load0(24'h0F1); load0(24'h0F2);
    arb_en = 2'b01;
    tick(1);
    arb_en = 2'b00;
    tick(6);
    w = '{24'h0F1}; s = '{0};
    chk_seq("en_clear", base, w, s);
    chk("en_clear_pulses", 32'(pulses0 - p0), 32'd1);
    chk("en_clear_rd_cnt0", 32'(rd_cnt0), 32'd1);

    // Mid-operation reset the cycle after a grant: in-flight word dropped.
    do_reset();
    base = got_data.size();
    load0(24'h0071); load0(24'h0072);
    arb_en = 2'b01;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rd_cnt0", 32'(rd_cnt0), 32'd0);
    reset = 1'b0;
    tick(6);
    w = '{24'h0072}; s = '{0};
    chk_seq("midrst_after", base, w, s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
